mopshub_can_tx_scheduler: RTL and testbench
===========================================

Name: mopshub_can_tx_scheduler

Overview:
- Downlink scheduler between the e-link frame decoder and the shared CAN transmit core of the 32-bus MOPSHUB.
- Buffers incoming 76-bit downlink frames with their target bus IDs in a small FIFO.
- Sequences one transmission at a time: drives can_tra_select and data_tra_downlink, then a start/done handshake with the CAN core.
- Handles per-frame timeout, bounded retry and dropping of frames addressed to invalid or disabled buses.

Parameters:
- DEPTH, 8, FIFO depth in frames; power of two, minimum 2.
- TIMEOUT_CYC, 40000, cycles waiting for tra_done before a timeout (1 ms at 40 MHz).
- MAX_RETRY, 2, retransmissions after a timeout before the frame is abandoned.

Ports:
- clk_40_m  in  1  system clock, 40 MHz.
- rst  in  1  reset, synchronous, active-low.
- n_buses  in  5  highest valid bus index; 31 means all buses are valid.
- bus_en  in  32  per-bus enable mask; bit i=1 means bus i is enabled.
- in_valid  in  1  frame offered by the e-link decoder.
- in_ready  out  1  scheduler can accept a frame.
- in_bus  in  5  target bus of the offered frame.
- in_data  in  76  offered frame.
- can_tra_select  out  5  bus selected for transmission.
- data_tra_downlink  out  76  frame presented to the CAN core.
- tra_start  out  1  one-cycle start pulse to the CAN core.
- tra_done  in  1  one-cycle completion pulse from the CAN core.
- irq_tra_ok  out  1  one-cycle pulse: frame sent.
- irq_tra_timeout  out  1  one-cycle pulse: frame abandoned after retries.
- irq_drop  out  1  one-cycle pulse: frame discarded because its bus is invalid.
- drop_cnt  out  8  saturating count of dropped plus abandoned frames.
- fifo_level  out  4  frames currently stored, 0..DEPTH.
- busy  out  1  state machine is not in IDLE.

Behaviour:
- Reset (rst=0 at a clk_40_m edge):
  - FIFO is flushed and the state machine returns to IDLE.
  - can_tra_select=0, data_tra_downlink=0.
  - All pulses=0, drop_cnt=0, fifo_level=0, busy=0.
  - in_ready is 0 during reset and 1 in the first cycle after reset.
  - Reset mid-transmission abandons the frame without any irq pulse.
- FIFO:
  - Push occurs when in_valid&&in_ready; in_ready = !full.
  - Pop occurs in state LOAD only.
  - Push and pop in the same cycle are both honoured and leave the level unchanged.
  - Pointers wrap modulo DEPTH.
  - in_valid while full is ignored; the decoder must hold the frame.
- State machine:
  - IDLE: if FIFO is non-empty, go to LOAD.
  - LOAD: pop the head entry. If in_bus>n_buses or bus_en[in_bus]==0, pulse irq_drop, increment drop_cnt and go to IDLE. Otherwise register the bus into can_tra_select and the frame into data_tra_downlink, clear the retry count and go to START.
  - START: tra_start=1 for exactly this cycle; clear the timeout counter; go to WAIT.
  - WAIT:
    - tra_done=1: pulse irq_tra_ok and go to IDLE.
    - Timeout counter reaches TIMEOUT_CYC-1 with retry<MAX_RETRY: increment retry and go to START.
    - Timeout counter reaches TIMEOUT_CYC-1 with retry==MAX_RETRY: pulse irq_tra_timeout, increment drop_cnt and go to IDLE.
    - tra_done takes priority over timeout in the same cycle.
- Latency: a frame accepted in cycle N into an empty FIFO with an idle scheduler gives LOAD in N+1 and tra_start in N+2. Back-to-back frames have a minimum of 3 cycles from tra_done to the next tra_start.
- can_tra_select and data_tra_downlink hold their values from LOAD until the next successful LOAD; they do not change during WAIT or retries.
- tra_done outside WAIT is ignored.
- drop_cnt saturates at 255.
- n_buses and bus_en are sampled only in LOAD.
- busy=1 in LOAD, START and WAIT.

Decomposition:
- Package mopshub_sched_pkg holds:
  - FRAME_W=76 and BUS_W=5.
  - The enum sched_state_t {IDLE, LOAD, START, WAIT}.
  - A struct sched_entry_t {bus, frame}.
- One sub-module, mopshub_frame_fifo: synchronous FIFO of sched_entry_t, parameter DEPTH, with push, pop, full, empty and level.
- The state machine, timeout and retry counters and the status outputs live in the top module.

Test Plan:
- Reset, then push one frame (bus 5, data 76'h0123456789ABCDEF012) → tra_start 2 cycles after accept; can_tra_select=5; data matches; tra_done 10 cycles later gives irq_tra_ok one cycle after it; busy drops.
- Push 8 frames while tra_done is withheld → in_ready=0 after the 8th; fifo_level=7 once the first is popped; a 9th in_valid is held off until a slot frees.
- n_buses=15: push a frame for bus 20, then a frame for bus 3 → irq_drop once; drop_cnt=1; bus 3 is transmitted normally.
- bus_en[7]=0 with a frame for bus 7 → dropped; no tra_start.
- Never assert tra_done, TIMEOUT_CYC=100 → 3 tra_start pulses 101 cycles apart; irq_tra_timeout after the third; drop_cnt increments.
- Assert rst=0 in WAIT with 3 frames queued → all outputs return to reset values; no irq pulses; after release fifo_level=0 and a new frame is serviced normally.

Source files
------------

// File: rtl/mopshub_can_tx_scheduler_pkg.sv
// Shared types for the MOPSHUB downlink CAN transmit scheduler.
package mopshub_sched_pkg;

  localparam int FRAME_W = 76;
  localparam int BUS_W   = 5;

  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} sched_state_t;

  typedef struct packed {
    logic [BUS_W-1:0]   bus;
    logic [FRAME_W-1:0] frame;
  } sched_entry_t;

  // A bus is usable only if it lies within the populated range and is enabled.
  function automatic logic bus_usable(input logic [BUS_W-1:0]        bus,
                                      input logic [BUS_W-1:0]        n_buses,
                                      input logic [(1<<BUS_W)-1:0]   bus_en);
    return (bus <= n_buses) && bus_en[bus];
  endfunction

endpackage

// File: rtl/mopshub_frame_fifo.sv
// Synchronous FIFO of scheduler entries with a first-word-fall-through read port.
module mopshub_frame_fifo
  import mopshub_sched_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_40_m,
  input  logic                     rst,
  input  logic                     push,
  input  sched_entry_t             wr_entry,
  input  logic                     pop,
  output sched_entry_t             rd_entry,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  sched_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign rd_entry = mem[rd_ptr];

  always_ff @(posedge clk_40_m) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      level <= level + (AW+1)'(1);
      else if (do_pop && !do_push) level <= level - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_40_m) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/mopshub_can_tx_scheduler.sv
// Downlink scheduler: queues frames, drives the shared CAN core one frame at a time.
// IDLE: wait for a frame | LOAD: pop and validate | START: pulse tra_start | WAIT: await tra_done or timeout
module mopshub_can_tx_scheduler
  import mopshub_sched_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 40000,
  parameter int MAX_RETRY   = 2
) (
  input  logic                clk_40_m,
  input  logic                rst,
  input  logic [BUS_W-1:0]    n_buses,
  input  logic [31:0]         bus_en,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BUS_W-1:0]    in_bus,
  input  logic [FRAME_W-1:0]  in_data,
  output logic [BUS_W-1:0]    can_tra_select,
  output logic [FRAME_W-1:0]  data_tra_downlink,
  output logic                tra_start,
  input  logic                tra_done,
  output logic                irq_tra_ok,
  output logic                irq_tra_timeout,
  output logic                irq_drop,
  output logic [7:0]          drop_cnt,
  output logic [3:0]          fifo_level,
  output logic                busy
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  sched_state_t  state, state_nxt;
  sched_entry_t  head, in_entry;
  logic          push, pop, full, empty;
  logic [LW-1:0] level;
  logic [TW-1:0] tmo_cnt;
  logic [RW-1:0] retry;
  logic          ev_load, ev_drop, ev_ok, ev_retry, ev_abandon;

  assign in_ready   = rst && !full;
  assign push       = in_valid && in_ready;
  assign in_entry   = '{bus: in_bus, frame: in_data};
  assign fifo_level = 4'(level);
  assign busy       = (state != IDLE);
  assign tra_start  = (state == START);

  mopshub_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_40_m (clk_40_m),
    .rst      (rst),
    .push     (push),
    .wr_entry (in_entry),
    .pop      (pop),
    .rd_entry (head),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  // Looking at push as well as !empty lets a frame into an idle FIFO reach LOAD one cycle later.
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    ev_load    = 1'b0;
    ev_drop    = 1'b0;
    ev_ok      = 1'b0;
    ev_retry   = 1'b0;
    ev_abandon = 1'b0;
    unique case (state)
      IDLE:  if (!empty || push) state_nxt = LOAD;
      LOAD: begin
        pop = 1'b1;
        if (bus_usable(head.bus, n_buses, bus_en)) begin
          ev_load   = 1'b1;
          state_nxt = START;
        end else begin
          ev_drop   = 1'b1;
          state_nxt = IDLE;
        end
      end
      START: state_nxt = WAIT;
      WAIT: begin
        if (tra_done) begin
          ev_ok     = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_cnt == '0) begin
          if (retry < RW'(MAX_RETRY)) begin
            ev_retry  = 1'b1;
            state_nxt = START;
          end else begin
            ev_abandon = 1'b1;
            state_nxt  = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_40_m) begin
    if (!rst) begin
      state             <= IDLE;
      can_tra_select    <= '0;
      data_tra_downlink <= '0;
      tmo_cnt           <= '0;
      retry             <= '0;
      irq_tra_ok        <= 1'b0;
      irq_tra_timeout   <= 1'b0;
      irq_drop          <= 1'b0;
      drop_cnt          <= '0;
    end else begin
      state           <= state_nxt;
      irq_tra_ok      <= ev_ok;
      irq_tra_timeout <= ev_abandon;
      irq_drop        <= ev_drop;
      if (ev_load) begin
        can_tra_select    <= head.bus;
        data_tra_downlink <= head.frame;
        retry             <= '0;
      end
      if (ev_retry) retry <= retry + RW'(1);
      // Down-counter: terminal count of zero marks TIMEOUT_CYC cycles spent in WAIT.
      if (tra_start)                          tmo_cnt <= TW'(TIMEOUT_CYC - 1);
      else if (state == WAIT && tmo_cnt != '0) tmo_cnt <= tmo_cnt - TW'(1);
      if ((ev_drop || ev_abandon) && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_mopshub_can_tx_scheduler.sv
// Scoreboard bench: accepted frames are expanded into expected CAN-core events by a queue model.
module tb_mopshub_can_tx_scheduler;

  localparam int DEPTH = 8;
  localparam int TMO   = 100;
  localparam int MAXR  = 2;

  logic        clk_40_m = 1'b0;
  logic        rst;
  logic [4:0]  cfg_n;
  logic [31:0] cfg_en;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_bus;
  logic [75:0] in_data;
  logic [4:0]  can_tra_select;
  logic [75:0] data_tra_downlink;
  logic        tra_start;
  logic        done_r = 1'b0;
  logic        stray;
  logic        irq_tra_ok, irq_tra_timeout, irq_drop;
  logic [7:0]  drop_cnt;
  logic [3:0]  fifo_level;
  logic        busy;

  mopshub_can_tx_scheduler #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR)) dut (
    .clk_40_m          (clk_40_m),
    .rst               (rst),
    .n_buses           (cfg_n),
    .bus_en            (cfg_en),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_bus            (in_bus),
    .in_data           (in_data),
    .can_tra_select    (can_tra_select),
    .data_tra_downlink (data_tra_downlink),
    .tra_start         (tra_start),
    .tra_done          (done_r | stray),
    .irq_tra_ok        (irq_tra_ok),
    .irq_tra_timeout   (irq_tra_timeout),
    .irq_drop          (irq_drop),
    .drop_cnt          (drop_cnt),
    .fifo_level        (fifo_level),
    .busy              (busy)
  );

  always #5 clk_40_m = ~clk_40_m;

  typedef enum {EV_START, EV_OK, EV_DROP, EV_TMO} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [4:0]  bus;
    logic [75:0] data;
    int          at_cyc;
    int          gap;
    int          drops;
  } ev_t;

  ev_t exp_q[$];
  int  resp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  mdrop = 0;
  int  last_start = 0;
  int  done_cyc = 0;
  bit  resp_active = 0;
  int  resp_delay = 0;
  int  resp_starts = 0;

  always @(posedge clk_40_m) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [75:0] act, logic [75:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [75:0] rand76();
    return {12'($urandom), $urandom, $urandom};
  endfunction

  // Expected event stream for one accepted frame, in the order the core must see it.
  function automatic void model_accept(logic [4:0] b, logic [75:0] d, int delay, int at);
    ev_t e;
    e = '{kind: EV_START, bus: b, data: d, at_cyc: at, gap: -1, drops: 0};
    if (b > cfg_n || !cfg_en[b]) begin
      if (mdrop < 255) mdrop++;
      e.kind  = EV_DROP;
      e.drops = mdrop;
      exp_q.push_back(e);
    end else begin
      exp_q.push_back(e);
      resp_q.push_back(delay);
      if (delay > 0) begin
        e.kind = EV_OK;
        exp_q.push_back(e);
      end else begin
        e.at_cyc = -1;
        e.gap    = TMO + 1;
        for (int r = 0; r < MAXR; r++) exp_q.push_back(e);
        if (mdrop < 255) mdrop++;
        e.kind  = EV_TMO;
        e.drops = mdrop;
        exp_q.push_back(e);
      end
    end
  endfunction

  function automatic void expect_ev(ev_kind_t k);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got %s at cycle %0d expected none", k.name(), cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != k) begin
      errors++;
      $display("FAIL event_kind: got %s expected %s (cycle %0d)", k.name(), e.kind.name(), cyc);
      return;
    end
    case (k)
      EV_START: begin
        chk("start_bus", can_tra_select, e.bus);
        chk("start_data", data_tra_downlink, e.data);
        if (e.at_cyc >= 0) chk("start_latency", cyc, e.at_cyc);
        if (e.gap >= 0)    chk("retry_gap", cyc - last_start, e.gap);
        last_start = cyc;
      end
      EV_OK:   chk("ok_latency", cyc, done_cyc + 1);
      EV_DROP: chk("drop_cnt_on_drop", drop_cnt, e.drops);
      EV_TMO: begin
        chk("timeout_latency", cyc - last_start, TMO + 1);
        chk("drop_cnt_on_timeout", drop_cnt, e.drops);
      end
      default: ;
    endcase
  endfunction

  always @(negedge clk_40_m) begin
    if (rst) begin
      if (tra_start)       expect_ev(EV_START);
      if (irq_tra_ok)      expect_ev(EV_OK);
      if (irq_drop)        expect_ev(EV_DROP);
      if (irq_tra_timeout) expect_ev(EV_TMO);
    end
  end

  // CAN core stand-in: answers each new frame after its scheduled delay, or never (delay 0).
  initial begin
    forever begin
      @(negedge clk_40_m);
      if (rst && tra_start) begin
        if (!resp_active) begin
          resp_delay  = (resp_q.size() > 0) ? resp_q.pop_front() : 0;
          resp_starts = 0;
          resp_active = 1;
        end
        resp_starts++;
        if (resp_delay > 0) begin
          repeat (resp_delay) @(negedge clk_40_m);
          done_r   = 1'b1;
          done_cyc = cyc;
          @(negedge clk_40_m);
          done_r      = 1'b0;
          resp_active = 0;
        end else if (resp_starts > MAXR) begin
          resp_active = 0;
        end
      end
    end
  end

  task automatic send(logic [4:0] b, logic [75:0] d, int delay, bit lat);
    int k = 0;
    in_valid = 1'b1;
    in_bus   = b;
    in_data  = d;
    #1;
    while (!in_ready && k < 2000) begin
      @(negedge clk_40_m);
      #1;
      k++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_accept: in_ready 0 after %0d cycles expected 1", k);
    end else begin
      model_accept(b, d, delay, lat ? cyc + 2 : -1);
    end
    @(negedge clk_40_m);
    in_valid = 1'b0;
  endtask

  task automatic drain(int limit);
    int k = 0;
    while ((exp_q.size() != 0 || busy || fifo_level != 0) && k < limit) begin
      @(negedge clk_40_m);
      k++;
    end
    checks++;
    if (k >= limit) begin
      errors++;
      $display("FAIL drain: %0d events pending busy %0d after %0d cycles expected 0", exp_q.size(), busy, k);
    end
  endtask

  function automatic void check_reset_vals(string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fifo_level"}, fifo_level, 0);
    chk({tag, "_select"}, can_tra_select, 0);
    chk({tag, "_data"}, data_tra_downlink, 0);
    chk({tag, "_drop_cnt"}, drop_cnt, 0);
    chk({tag, "_tra_start"}, tra_start, 0);
    chk({tag, "_irqs"}, {irq_tra_ok, irq_tra_timeout, irq_drop}, 0);
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  b;
    logic [75:0] d;
    int          k;
    rst = 1'b0; in_valid = 1'b0; in_bus = '0; in_data = '0; stray = 1'b0;
    cfg_n = 5'd31; cfg_en = '1;
    repeat (3) @(negedge clk_40_m);
    check_reset_vals("init");
    rst = 1'b1;
    #1 chk("init_ready_after_reset", in_ready, 1);
    @(negedge clk_40_m);

    // Single frame: start two cycles after accept, ok one cycle after done.
    send(5'd5, 76'h0123456789ABCDEF012, 10, 1);
    drain(500);

    // Fill the FIFO behind a frame held in WAIT.
    send(5'd1, rand76(), 60, 0);
    repeat (2) @(negedge clk_40_m);
    for (int i = 0; i < 8; i++) send(5'($urandom_range(0, 31)), rand76(), $urandom_range(1, 100), 0);
    chk("full_in_ready", in_ready, 0);
    chk("full_level", fifo_level, 8);
    b = 5'($urandom_range(0, 31));
    d = rand76();
    in_valid = 1'b1; in_bus = b; in_data = d;
    #1 chk("ninth_held_off", in_ready, 0);
    k = 0;
    while (!in_ready && k < 500) begin
      @(negedge clk_40_m);
      #1;
      k++;
    end
    chk("ninth_accepted", in_ready, 1);
    chk("level_after_first_pop", fifo_level, 7);
    if (in_ready) model_accept(b, d, $urandom_range(1, 100), -1);
    @(negedge clk_40_m);
    in_valid = 1'b0;
    drain(3000);

    // Out-of-range bus, then a valid one.
    cfg_n = 5'd15;
    send(5'd20, rand76(), 5, 0);
    send(5'd3, rand76(), 7, 0);
    drain(500);
    chk("drop_cnt_range", drop_cnt, 1);
    cfg_n = 5'd31;

    // Disabled bus.
    cfg_en[7] = 1'b0;
    send(5'd7, rand76(), 5, 0);
    drain(500);
    chk("drop_cnt_disabled", drop_cnt, 2);
    cfg_en = '1;

    // Done arriving in the same cycle as the timeout wins.
    send(5'd9, rand76(), TMO, 0);
    drain(500);

    // No done at all: two retries then abandon.
    send(5'd12, rand76(), 0, 0);
    drain(1000);
    chk("drop_cnt_abandon", drop_cnt, 3);

    // Done while idle must be ignored.
    stray = 1'b1;
    @(negedge clk_40_m);
    stray = 1'b0;
    chk("stray_done_irq", irq_tra_ok, 0);
    chk("stray_done_busy", busy, 0);

    // Random traffic with configuration changed between drained batches.
    for (int batch = 0; batch < 6; batch++) begin
      cfg_n  = 5'($urandom_range(8, 31));
      cfg_en = $urandom | $urandom | $urandom;
      for (int i = 0; i < 5; i++) begin
        send(5'($urandom), rand76(), ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 100), 0);
        repeat ($urandom_range(0, 3)) @(negedge clk_40_m);
      end
      drain(3000);
    end
    cfg_n = 5'd31;

    // Enough drops to saturate the counter.
    cfg_en = 32'hFFFF_FFFE;
    for (int i = 0; i < 260; i++) send(5'd0, rand76(), 1, 0);
    drain(2000);
    chk("drop_cnt_saturated", drop_cnt, 255);
    cfg_en = '1;

    // Reset while a frame sits in WAIT with three more queued.
    send(5'd9, rand76(), 0, 0);
    repeat (6) @(negedge clk_40_m);
    for (int i = 0; i < 3; i++) send(5'($urandom_range(0, 31)), rand76(), 5, 0);
    chk("queued_before_reset", fifo_level, 3);
    rst = 1'b0;
    @(negedge clk_40_m);
    check_reset_vals("mid");
    exp_q.delete();
    resp_q.delete();
    resp_active = 0;
    mdrop = 0;
    @(negedge clk_40_m);
    rst = 1'b1;
    #1 chk("mid_ready_after_reset", in_ready, 1);
    chk("mid_level_after_reset", fifo_level, 0);
    @(negedge clk_40_m);
    send(5'd4, rand76(), 5, 0);
    drain(500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
